// File: rtl/ir_key_event.sv
// NEC key event generator: turns decoded IR frames into PRESS/REPEAT/RELEASE
// events and queues them in a 4-entry show-ahead FIFO.
module ir_key_event #(
    parameter bit          ADDR_FILTER_EN = 1'b1,
    parameter logic [7:0]  DEV_ADDR       = 8'h00,
    parameter int          HOLD_TIMEOUT   = 6000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    input  logic        iEVT_READY,
    output logic        oEVT_VALID,
    output logic [7:0]  oEVT_CMD,
    output logic [1:0]  oEVT_TYPE,
    output logic        oKEY_HELD,
    output logic [7:0]  oREJ_CNT,
    output logic [7:0]  oDROP_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [1:0]  EVT_PRESS   = 2'b00;
    localparam logic [1:0]  EVT_REPEAT  = 2'b01;
    localparam logic [1:0]  EVT_RELEASE = 2'b10;
    localparam logic [22:0] TIMEOUT_LAST = 23'(HOLD_TIMEOUT - 1);

    function automatic logic cmd_check_ok(input logic [31:0] frame);
        cmd_check_ok = (frame[31:24] == ~frame[23:16]);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, v} + {7'b0000000, inc};
        sat_add = (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

    state_t      state_r, state_next_s;
    logic [7:0]  held_cmd_r, held_cmd_next_s;
    logic [7:0]  pend_cmd_r, pend_cmd_next_s;
    logic [22:0] timer_r, timer_next_s;

    logic        frame_ok_s, accept_s, reject_s;
    logic        push_s, wr_s, pop_s, drop_push_s, sw_discard_s;
    logic [1:0]  push_type_s, drop_inc_s;
    logic [7:0]  push_cmd_s;

    logic [9:0]  fifo_mem_r [4];
    logic [1:0]  wr_ptr_r, rd_ptr_r;
    logic [2:0]  count_r;
    logic [7:0]  rej_cnt_r, drop_cnt_r;

    // The address-extension byte carries no meaning for this block.
    logic unused_ext_s;
    assign unused_ext_s = &{1'b0, iDATA[15:8]};

    assign frame_ok_s = cmd_check_ok(iDATA) &&
                        ((ADDR_FILTER_EN == 1'b0) || (iDATA[7:0] == DEV_ADDR));
    assign accept_s   = iDATA_READY && frame_ok_s;
    assign reject_s   = iDATA_READY && !frame_ok_s;

    // Next-state, event push and hold-timer control.
    always_comb begin
        state_next_s    = state_r;
        held_cmd_next_s = held_cmd_r;
        pend_cmd_next_s = pend_cmd_r;
        timer_next_s    = timer_r;
        push_s          = 1'b0;
        push_type_s     = EVT_PRESS;
        push_cmd_s      = 8'h00;
        sw_discard_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    push_s          = 1'b1;
                    push_type_s     = EVT_PRESS;
                    push_cmd_s      = iDATA[23:16];
                    held_cmd_next_s = iDATA[23:16];
                    timer_next_s    = 23'd0;
                    state_next_s    = ST_HELD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HELD: begin
                // A frame landing on the timeout cycle beats the timeout.
                if (accept_s) begin
                    push_s = 1'b1;
                    if (iDATA[23:16] == held_cmd_r) begin
                        push_type_s  = EVT_REPEAT;
                        push_cmd_s   = held_cmd_r;
                        timer_next_s = 23'd0;
                    end else begin
                        push_type_s     = EVT_RELEASE;
                        push_cmd_s      = held_cmd_r;
                        pend_cmd_next_s = iDATA[23:16];
                        state_next_s    = ST_SWITCH;
                    end
                end else if (timer_r == TIMEOUT_LAST) begin
                    push_s       = 1'b1;
                    push_type_s  = EVT_RELEASE;
                    push_cmd_s   = held_cmd_r;
                    state_next_s = ST_IDLE;
                end else begin
                    timer_next_s = timer_r + 23'd1;
                end
            end
            ST_SWITCH: begin
                push_s          = 1'b1;
                push_type_s     = EVT_PRESS;
                push_cmd_s      = pend_cmd_r;
                held_cmd_next_s = pend_cmd_r;
                timer_next_s    = 23'd0;
                state_next_s    = ST_HELD;
                sw_discard_s    = iDATA_READY;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign pop_s       = (count_r != 3'd0) && iEVT_READY;
    assign wr_s        = push_s && ((count_r != 3'd4) || pop_s);
    assign drop_push_s = push_s && !wr_s;
    assign drop_inc_s  = {1'b0, drop_push_s} + {1'b0, sw_discard_s};

    // FSM, key registers and hold timer.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r    <= ST_IDLE;
            held_cmd_r <= 8'h00;
            pend_cmd_r <= 8'h00;
            timer_r    <= 23'd0;
        end else begin
            state_r    <= state_next_s;
            held_cmd_r <= held_cmd_next_s;
            pend_cmd_r <= pend_cmd_next_s;
            timer_r    <= timer_next_s;
        end
    end

    // Event FIFO storage, pointers and occupancy.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 10'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (wr_s) begin
                fifo_mem_r[wr_ptr_r] <= {push_type_s, push_cmd_s};
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating reject / drop statistics.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rej_cnt_r  <= 8'h00;
            drop_cnt_r <= 8'h00;
        end else begin
            rej_cnt_r  <= sat_add(rej_cnt_r, {1'b0, reject_s});
            drop_cnt_r <= sat_add(drop_cnt_r, drop_inc_s);
        end
    end

    assign oEVT_VALID = (count_r != 3'd0);
    assign oEVT_CMD   = fifo_mem_r[rd_ptr_r][7:0];
    assign oEVT_TYPE  = fifo_mem_r[rd_ptr_r][9:8];
    assign oKEY_HELD  = (state_r == ST_HELD) || (state_r == ST_SWITCH);
    assign oREJ_CNT   = rej_cnt_r;
    assign oDROP_CNT  = drop_cnt_r;

endmodule

// File: tb/tb_ir_key_event.sv
// Directed self-checking bench for ir_key_event (HOLD_TIMEOUT shortened to 100).
module tb_ir_key_event;

    logic        iCLK;
    logic        iRST;
    logic        iDATA_READY;
    logic [31:0] iDATA;
    logic        iEVT_READY;
    logic        oEVT_VALID;
    logic [7:0]  oEVT_CMD;
    logic [1:0]  oEVT_TYPE;
    logic        oKEY_HELD;
    logic [7:0]  oREJ_CNT;
    logic [7:0]  oDROP_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] PRESS   = 2'b00;
    localparam logic [1:0] REPEAT  = 2'b01;
    localparam logic [1:0] RELEASE = 2'b10;

    ir_key_event #(
        .ADDR_FILTER_EN (1'b1),
        .DEV_ADDR       (8'h00),
        .HOLD_TIMEOUT   (100)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iDATA_READY (iDATA_READY),
        .iDATA       (iDATA),
        .iEVT_READY  (iEVT_READY),
        .oEVT_VALID  (oEVT_VALID),
        .oEVT_CMD    (oEVT_CMD),
        .oEVT_TYPE   (oEVT_TYPE),
        .oKEY_HELD   (oKEY_HELD),
        .oREJ_CNT    (oREJ_CNT),
        .oDROP_CNT   (oDROP_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] frame(input logic [7:0] addr, input logic [7:0] cmd);
        frame = {~cmd, cmd, 8'h00, addr};
    endfunction

    task automatic send(input logic [31:0] f);
        iDATA       = f;
        iDATA_READY = 1'b1;
        tick;
        iDATA_READY = 1'b0;
    endtask

    task automatic chk_head(input string tag, input logic [1:0] typ, input logic [7:0] cmd);
        chk({tag, "_valid"}, {31'd0, oEVT_VALID}, 32'd1);
        chk({tag, "_type"}, {30'd0, oEVT_TYPE}, {30'd0, typ});
        chk({tag, "_cmd"}, {24'd0, oEVT_CMD}, {24'd0, cmd});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  found;
        iRST        = 1'b1;
        iDATA_READY = 1'b0;
        iDATA       = 32'd0;
        iEVT_READY  = 1'b1;
        tick;
        tick;
        iRST = 1'b0;
        chk("rst_valid", {31'd0, oEVT_VALID}, 32'd0);
        chk("rst_held", {31'd0, oKEY_HELD}, 32'd0);
        chk("rst_rej", {24'd0, oREJ_CNT}, 32'd0);
        chk("rst_drop", {24'd0, oDROP_CNT}, 32'd0);

        // Press, repeat, then timeout release.
        send(32'hBF40_0000);
        chk_head("press40", PRESS, 8'h40);
        chk("press40_held", {31'd0, oKEY_HELD}, 32'd1);
        repeat (50) tick;
        chk("gap_empty", {31'd0, oEVT_VALID}, 32'd0);
        send(32'hBF40_0000);
        chk_head("rep40", REPEAT, 8'h40);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick;
            n++;
            if (oEVT_VALID && oEVT_TYPE == RELEASE) found = 1'b1;
        end
        chk("timeout_cycles", n, 32'd100);
        chk("rel40_cmd", {24'd0, oEVT_CMD}, 32'h40);
        chk("rel40_held", {31'd0, oKEY_HELD}, 32'd0);
        tick;
        chk("rel40_popped", {31'd0, oEVT_VALID}, 32'd0);

        // Rejected frames: bad checksum, wrong address.
        send(32'h0012_0000);
        send(frame(8'h05, 8'h22));
        chk("rej_valid", {31'd0, oEVT_VALID}, 32'd0);
        chk("rej_cnt", {24'd0, oREJ_CNT}, 32'd2);
        chk("rej_held", {31'd0, oKEY_HELD}, 32'd0);

        // Key switch 12 -> 34, with a pulse discarded during SWITCH.
        iEVT_READY = 1'b0;
        send(frame(8'h00, 8'h12));
        chk("sw_held1", {31'd0, oKEY_HELD}, 32'd1);
        send(frame(8'h00, 8'h34));
        chk("sw_held2", {31'd0, oKEY_HELD}, 32'd1);
        send(frame(8'h00, 8'h34));
        chk("sw_held3", {31'd0, oKEY_HELD}, 32'd1);
        chk("sw_drop", {24'd0, oDROP_CNT}, 32'd1);
        iEVT_READY = 1'b1;
        chk_head("sw_e0", PRESS, 8'h12);
        tick;
        chk_head("sw_e1", RELEASE, 8'h12);
        tick;
        chk_head("sw_e2", PRESS, 8'h34);
        tick;
        chk("sw_empty", {31'd0, oEVT_VALID}, 32'd0);
        chk("sw_held4", {31'd0, oKEY_HELD}, 32'd1);

        // Overflow: six events into a stalled FIFO.
        iEVT_READY = 1'b0;
        send(frame(8'h00, 8'h56));
        tick;
        send(frame(8'h00, 8'h56));
        send(frame(8'h00, 8'h77));
        tick;
        send(frame(8'h00, 8'h77));
        chk_head("ovf_head", RELEASE, 8'h34);
        chk("ovf_drop", {24'd0, oDROP_CNT}, 32'd3);
        // Push and pop together while full.
        iEVT_READY = 1'b1;
        send(frame(8'h00, 8'h77));
        chk("pp_drop", {24'd0, oDROP_CNT}, 32'd3);
        chk_head("pp_e0", PRESS, 8'h56);
        tick;
        chk_head("pp_e1", REPEAT, 8'h56);
        tick;
        chk_head("pp_e2", RELEASE, 8'h56);
        tick;
        chk_head("pp_e3", REPEAT, 8'h77);
        tick;
        chk("pp_empty", {31'd0, oEVT_VALID}, 32'd0);

        // Frame on the exact timeout cycle wins.
        send(frame(8'h00, 8'h77));
        chk_head("tb_rep", REPEAT, 8'h77);
        repeat (99) tick;
        chk("tb_quiet", {31'd0, oEVT_VALID}, 32'd0);
        send(frame(8'h00, 8'h77));
        chk_head("tb_win", REPEAT, 8'h77);
        chk("tb_held", {31'd0, oKEY_HELD}, 32'd1);
        tick;
        chk("tb_norel", {31'd0, oEVT_VALID}, 32'd0);
        repeat (50) tick;
        chk("tb_rearm", {31'd0, oEVT_VALID}, 32'd0);
        chk("tb_held2", {31'd0, oKEY_HELD}, 32'd1);

        // Reset while held with queued events and a frame present.
        iEVT_READY = 1'b0;
        send(frame(8'h00, 8'h77));
        send(frame(8'h00, 8'h77));
        send(frame(8'h00, 8'h77));
        chk("mr_queued", {31'd0, oEVT_VALID}, 32'd1);
        iRST        = 1'b1;
        iDATA       = frame(8'h00, 8'h77);
        iDATA_READY = 1'b1;
        tick;
        iRST        = 1'b0;
        iDATA_READY = 1'b0;
        chk("mr_valid", {31'd0, oEVT_VALID}, 32'd0);
        chk("mr_rej", {24'd0, oREJ_CNT}, 32'd0);
        chk("mr_drop", {24'd0, oDROP_CNT}, 32'd0);
        chk("mr_held", {31'd0, oKEY_HELD}, 32'd0);
        repeat (150) tick;
        chk("mr_norel", {31'd0, oEVT_VALID}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ir_key_event.md
IR_KEY_EVENT -- requirements
Module: ir_key_event

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_FILTER_EN, 1, 1 = accept only frames whose iDATA[7:0] equals DEV_ADDR.
- DEV_ADDR, 8'h00, device address to match.
- HOLD_TIMEOUT, 6000000, cycles without an accepted frame before RELEASE (120 ms at 50 MHz).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- iCLK, in, 1, 50 MHz clock; single clock domain.
- iRST, in, 1, synchronous, active-high reset.
- iDATA_READY, in, 1, one-cycle pulse; a decoded NEC frame is present on iDATA.
- iDATA, in, 32, frame: [7:0] address, [15:8] address complement/extension, [23:16] command, [31:24] ~command.
- iEVT_READY, in, 1, consumer accepts the head event.
- oEVT_VALID, out, 1, event FIFO not empty.
- oEVT_CMD, out, 8, command of the head event.
- oEVT_TYPE, out, 2, head event type: 00 PRESS, 01 REPEAT, 10 RELEASE; 11 never produced.
- oKEY_HELD, out, 1, FSM is in HELD or SWITCH.
- oREJ_CNT, out, 8, rejected frames, saturating.
- oDROP_CNT, out, 8, events lost to a full FIFO, saturating.

Function
REQ-003 A frame SHALL be accepted when all of the following hold:
- iDATA_READY = 1.
- iDATA[31:24] == ~iDATA[23:16].
- ADDR_FILTER_EN == 0, or iDATA[7:0] == DEV_ADDR.
Any other iDATA_READY pulse is a rejected frame.
REQ-004 A rejected frame SHALL increment oREJ_CNT, saturating at 255. It SHALL NOT affect the FSM, the timer or the FIFO.
REQ-005 FSM states SHALL be IDLE, HELD and SWITCH. The block SHALL hold registers held_cmd[7:0], pend_cmd[7:0] and a 23-bit hold timer.
REQ-006 IDLE, accepted frame C: push PRESS C; held_cmd <= C; timer <= 0; go to HELD.
REQ-007 HELD, accepted frame with C == held_cmd: push REPEAT C; timer <= 0; stay in HELD.
REQ-008 HELD, accepted frame with C != held_cmd: push RELEASE held_cmd; pend_cmd <= C; go to SWITCH.
REQ-009 SWITCH: unconditionally, on the next cycle, push PRESS pend_cmd; held_cmd <= pend_cmd; timer <= 0; go to HELD.
REQ-010 Any iDATA_READY pulse arriving while in SWITCH SHALL be discarded and SHALL increment oDROP_CNT.
REQ-011 In HELD with no accepted frame, the timer SHALL increment by 1 each cycle. When timer == HOLD_TIMEOUT-1: push RELEASE held_cmd; go to IDLE.
REQ-012 Timeout versus frame in the same cycle: the accepted frame SHALL win (REQ-007/008 apply) and no RELEASE is pushed for the timeout.
REQ-013 The FIFO SHALL be 4 entries of 10 bits {type, cmd}, show-ahead. oEVT_CMD and oEVT_TYPE SHALL come directly from the head entry registers. oEVT_VALID = (count != 0).
REQ-014 Pop SHALL occur when oEVT_VALID && iEVT_READY.
REQ-015 Push when count == 4 with no pop in that cycle: the event SHALL be dropped and oDROP_CNT incremented (saturating at 255). FSM transitions SHALL still occur.
REQ-016 Push and pop in the same cycle SHALL both succeed at any count, including 4 (count unchanged). Read and write pointers SHALL wrap modulo 4.
REQ-017 Latency: accepted frame at cycle N -> event written at the end of cycle N; oEVT_VALID high from N+1 when the FIFO was empty.
REQ-018 oEVT_VALID and the head data SHALL remain stable until popped.

Reset
REQ-019 iRST = 1 sampled at a clock edge SHALL set:
- FSM to IDLE;
- timer, held_cmd and pend_cmd to 0;
- FIFO pointers and count to 0 (oEVT_VALID = 0);
- oKEY_HELD = 0, oREJ_CNT = 0, oDROP_CNT = 0.
Reset SHALL take precedence over every other event.
REQ-020 Reset mid-hold SHALL NOT emit RELEASE. Events already queued SHALL be discarded.

Verification
REQ-021 Frame 32'hBF40_00_00 (cmd 8'h40), iEVT_READY = 1 -> PRESS 40 at N+1. Second identical frame 5 ms later -> REPEAT 40. No frame for HOLD_TIMEOUT cycles -> RELEASE 40; oKEY_HELD = 0.
REQ-022 Frames with cmd 8'h12 then cmd 8'h34 while held -> events PRESS 12, RELEASE 12, PRESS 34 on consecutive push cycles; oKEY_HELD stays 1.
REQ-023 Bad checksum 32'h0012_0000, then address 8'h05 with DEV_ADDR = 0 -> no events; oREJ_CNT = 2; FSM stays in IDLE.
REQ-024 iEVT_READY = 0, six accepted events -> count 4; oDROP_CNT = 2; the head is the first event. A push and a pop in the same cycle at count 4 -> count 4; order preserved.
REQ-025 Set HOLD_TIMEOUT = 100. Frame arriving on the timeout cycle -> REPEAT, no RELEASE.
REQ-026 iRST asserted in HELD with 3 events queued -> next cycle oEVT_VALID = 0, counters 0, FSM in IDLE, and no RELEASE afterwards.
